// File: rtl/rd_ack_mng_pkg.sv
// Shared constants for the CAM read-back path: register addresses, trigger bit,
// per-bit encoding values and FSM state encodings.
package rd_ack_mng_pkg;

   localparam logic [7:0] ADDR_STATUS = 8'h10;
   localparam logic [7:0] ADDR_DATA   = 8'h11;
   localparam logic [7:0] ADDR_INDEX  = 8'h12;
   localparam logic [7:0] ADDR_TRIG   = 8'h13;

   localparam int TRIG_BIT = 15;

   localparam logic [1:0] ENC_ZERO = 2'b00;
   localparam logic [1:0] ENC_ONE  = 2'b01;
   localparam logic [1:0] ENC_X    = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // Two-bit code for one entry bit; a don't-care bit overrides its data value.
   function automatic logic [1:0] enc_bit(input logic d, input logic m_eff);
      return m_eff ? ENC_X : (d ? ENC_ONE : ENC_ZERO);
   endfunction

endpackage

// File: rtl/cam_x_encoder.sv
// Combinational re-encoder: N data bits plus mask to 2N-bit code (0->00, 1->01, x->10).
// In CAM mode the mask is ignored so every bit encodes as a plain 0/1.
module cam_x_encoder
   import rd_ack_mng_pkg::*;
#(
   parameter int N         = 8,
   parameter int CAM_MODEL = 1
) (
   input  logic [N-1:0]   data,
   input  logic [N-1:0]   mask,
   output logic [2*N-1:0] code
);

   logic [N-1:0] mask_eff;
   logic         mask_unused;

   // Keeps the mask visibly consumed when CAM mode folds it away.
   assign mask_unused = ^mask;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_bit
         assign mask_eff[gi]      = (CAM_MODEL == 0) ? mask[gi] : 1'b0;
         assign code[2*gi +: 2]   = enc_bit(data[gi], mask_eff[gi]);
      end
   endgenerate

endmodule

// File: rtl/rd_ack_mng.sv
// CAM/TCAM entry read-back manager. A register write to the trigger address
// issues a one-cycle read request; the response is encoded and held in
// read-only registers with busy/done/timeout status and an error counter.
// Optional WAIT timeout enabled by defining CAM_RD_TIMEOUT_EN.
module rd_ack_mng
   import rd_ack_mng_pkg::*;
#(
   parameter int PORT_MNG_DATA_WIDTH = 8,
   parameter int CAM_MODEL           = 1,
   parameter int REG_ADDR_BUS_WIDTH  = 8,
   parameter int REG_DATA_BUS_WIDTH  = 16,
   parameter int DATA_CNT_WIDTH      = 6,
   parameter int TIMEOUT_CYCLES      = 255
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   output logic                           o_read_req,
   output logic [DATA_CNT_WIDTH-1:0]      o_read_cnt,
   input  logic [PORT_MNG_DATA_WIDTH-1:0] i_read_data,
   input  logic [PORT_MNG_DATA_WIDTH-1:0] i_read_mask,
   input  logic                           i_read_data_vld,
   input  logic                           i_refresh_list_pulse,
   input  logic                           i_switch_err_cnt_clr,
   input  logic                           i_switch_reg_bus_we,
   input  logic [REG_ADDR_BUS_WIDTH-1:0]  i_switch_reg_bus_we_addr,
   input  logic [REG_DATA_BUS_WIDTH-1:0]  i_switch_reg_bus_we_din,
   input  logic                           i_switch_reg_bus_we_din_v,
   input  logic                           i_switch_reg_bus_rd,
   input  logic [REG_ADDR_BUS_WIDTH-1:0]  i_switch_reg_bus_rd_addr,
   output logic [REG_DATA_BUS_WIDTH-1:0]  o_switch_reg_bus_rd_dout,
   output logic                           o_switch_reg_bus_rd_dout_v
);

   localparam int ENC_W = 2 * PORT_MNG_DATA_WIDTH;

   state_t                        state_reg, state_next;
   logic [DATA_CNT_WIDTH-1:0]     index_reg;
   logic [REG_DATA_BUS_WIDTH-1:0] data_reg;
   logic [REG_DATA_BUS_WIDTH-1:0] dout_reg, dout_next;
   logic                          dout_v_reg;
   logic                          done_reg;
   logic                          timeout_reg;
   logic [7:0]                    err_cnt_reg;
   logic [ENC_W-1:0]              enc_code;
   logic                          trig_hit, trig_accept, collision, resp_accept;
   logic                          timeout_hit, err_inc, busy;
   logic                          din_unused;

   assign din_unused = ^i_switch_reg_bus_we_din;

   assign trig_hit = i_switch_reg_bus_we && i_switch_reg_bus_we_din_v &&
                     (i_switch_reg_bus_we_addr == ADDR_TRIG) &&
                     i_switch_reg_bus_we_din[TRIG_BIT];

   cam_x_encoder #(
      .N         (PORT_MNG_DATA_WIDTH),
      .CAM_MODEL (CAM_MODEL)
   ) u_enc (
      .data (i_read_data),
      .mask (i_read_mask),
      .code (enc_code)
   );

`ifdef CAM_RD_TIMEOUT_EN
   logic [7:0] to_cnt_reg;

   assign timeout_hit = (state_reg == ST_WAIT) && !i_read_data_vld &&
                        (to_cnt_reg == 8'(TIMEOUT_CYCLES - 1));

   // WAIT-cycle counter, restarted every time WAIT is entered.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                    to_cnt_reg <= '0;
      else if (state_reg != ST_WAIT) to_cnt_reg <= '0;
      else                          to_cnt_reg <= to_cnt_reg + 8'd1;
   end

   // Sticky timeout flag; a new timeout beats a simultaneous refresh.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                     timeout_reg <= 1'b0;
      else if (timeout_hit)          timeout_reg <= 1'b1;
      else if (i_refresh_list_pulse) timeout_reg <= 1'b0;
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
   assign timeout_reg = 1'b0;
`endif

   // Next-state and transaction-event decode.
   always_comb begin
      state_next  = state_reg;
      trig_accept = 1'b0;
      collision   = 1'b0;
      resp_accept = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (trig_hit) begin
               trig_accept = 1'b1;
               state_next  = ST_REQ;
            end
         end
         ST_REQ: begin
            collision  = trig_hit;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            collision = trig_hit;
            if (i_read_data_vld) begin
               resp_accept = 1'b1;
               state_next  = ST_IDLE;
            end else if (timeout_hit) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   assign busy       = (state_reg != ST_IDLE);
   assign o_read_req = (state_reg == ST_REQ);
   assign o_read_cnt = index_reg;
   assign err_inc    = collision | timeout_hit;

   // Index latched on an accepted trigger.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)            index_reg <= '0;
      else if (trig_accept) index_reg <= i_switch_reg_bus_we_din[DATA_CNT_WIDTH-1:0];
   end

   // Encoded data: loaded on a response, wiped on a timeout.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)            data_reg <= '0;
      else if (resp_accept) data_reg <= REG_DATA_BUS_WIDTH'(enc_code);
      else if (timeout_hit) data_reg <= '0;
   end

   // Done flag: set by a response (wins over refresh), cleared by refresh or new trigger.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                     done_reg <= 1'b0;
      else if (resp_accept)          done_reg <= 1'b1;
      else if (i_refresh_list_pulse) done_reg <= 1'b0;
      else if (trig_accept)          done_reg <= 1'b0;
   end

   // Saturating error counter; clear has priority over an increment.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                  err_cnt_reg <= '0;
      else if (i_switch_err_cnt_clr)              err_cnt_reg <= '0;
      else if (err_inc && (err_cnt_reg != 8'hFF)) err_cnt_reg <= err_cnt_reg + 8'd1;
   end

   // Register read mux; unmapped addresses return zero.
   always_comb begin
      dout_next = '0;
      case (i_switch_reg_bus_rd_addr)
         REG_ADDR_BUS_WIDTH'(ADDR_STATUS):
            dout_next = REG_DATA_BUS_WIDTH'({err_cnt_reg, 5'd0, timeout_reg, done_reg, busy});
         REG_ADDR_BUS_WIDTH'(ADDR_DATA):  dout_next = data_reg;
         REG_ADDR_BUS_WIDTH'(ADDR_INDEX): dout_next = REG_DATA_BUS_WIDTH'(index_reg);
         default:                         dout_next = '0;
      endcase
   end

   // Read data registered one cycle after the strobe and held between reads.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         dout_reg   <= '0;
         dout_v_reg <= 1'b0;
      end else begin
         dout_v_reg <= i_switch_reg_bus_rd;
         if (i_switch_reg_bus_rd) dout_reg <= dout_next;
      end
   end

   assign o_switch_reg_bus_rd_dout   = dout_reg;
   assign o_switch_reg_bus_rd_dout_v = dout_v_reg;

endmodule

// File: tb/tb_rd_ack_mng.sv
// Directed bench for rd_ack_mng: one CAM and one TCAM instance share stimulus.
// Timeout scenario depends on CAM_RD_TIMEOUT_EN.
module tb_rd_ack_mng;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  read_data, read_mask;
   logic        read_vld, refresh, err_clr;
   logic        we, din_v, rd;
   logic [7:0]  we_addr, rd_addr;
   logic [15:0] din;

   logic        req_c, req_t, dv_c, dv_t;
   logic [5:0]  cnt_c, cnt_t;
   logic [15:0] dout_c, dout_t;
   logic [15:0] rc, rt;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rd_ack_mng #(.CAM_MODEL(1), .TIMEOUT_CYCLES(10)) dut_c (
      .i_clk(clk), .i_rst(rst),
      .o_read_req(req_c), .o_read_cnt(cnt_c),
      .i_read_data(read_data), .i_read_mask(read_mask), .i_read_data_vld(read_vld),
      .i_refresh_list_pulse(refresh), .i_switch_err_cnt_clr(err_clr),
      .i_switch_reg_bus_we(we), .i_switch_reg_bus_we_addr(we_addr),
      .i_switch_reg_bus_we_din(din), .i_switch_reg_bus_we_din_v(din_v),
      .i_switch_reg_bus_rd(rd), .i_switch_reg_bus_rd_addr(rd_addr),
      .o_switch_reg_bus_rd_dout(dout_c), .o_switch_reg_bus_rd_dout_v(dv_c)
   );

   rd_ack_mng #(.CAM_MODEL(0), .TIMEOUT_CYCLES(10)) dut_t (
      .i_clk(clk), .i_rst(rst),
      .o_read_req(req_t), .o_read_cnt(cnt_t),
      .i_read_data(read_data), .i_read_mask(read_mask), .i_read_data_vld(read_vld),
      .i_refresh_list_pulse(refresh), .i_switch_err_cnt_clr(err_clr),
      .i_switch_reg_bus_we(we), .i_switch_reg_bus_we_addr(we_addr),
      .i_switch_reg_bus_we_din(din), .i_switch_reg_bus_we_din_v(din_v),
      .i_switch_reg_bus_rd(rd), .i_switch_reg_bus_rd_addr(rd_addr),
      .o_switch_reg_bus_rd_dout(dout_t), .o_switch_reg_bus_rd_dout_v(dv_t)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic trig(input logic [15:0] d);
      we = 1'b1; we_addr = 8'h13; din = d; din_v = 1'b1;
      step();
      we = 1'b0; din_v = 1'b0;
      $display("trigger din=0x%04h", d);
   endtask

   task automatic respond(input logic [7:0] d, input logic [7:0] m);
      read_data = d; read_mask = m; read_vld = 1'b1;
      step();
      read_vld = 1'b0;
      $display("response data=0x%02h mask=0x%02h", d, m);
   endtask

   task automatic rd_reg(input logic [7:0] a);
      rd = 1'b1; rd_addr = a;
      step();
      rd = 1'b0;
      rc = dout_c; rt = dout_t;
      chk("dout_v_c", 32'(dv_c), 32'd1);
      chk("dout_v_t", 32'(dv_t), 32'd1);
      $display("read addr=0x%02h cam=0x%04h tcam=0x%04h", a, rc, rt);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a,
                         input logic [15:0] exp_c, input logic [15:0] exp_t);
      rd_reg(a);
      chk({tag, "_cam"}, 32'(rc), 32'(exp_c));
      chk({tag, "_tcam"}, 32'(rt), 32'(exp_t));
   endtask

   initial begin
      rst = 1'b1; read_data = '0; read_mask = '0; read_vld = 1'b0;
      refresh = 1'b0; err_clr = 1'b0; we = 1'b0; din_v = 1'b0; rd = 1'b0;
      we_addr = '0; rd_addr = '0; din = '0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Reset state
      chk("rst_req", 32'({req_c, req_t}), 32'd0);
      chk("rst_dout", 32'({dout_c, dout_t, dv_c, dv_t}), 32'd0);
      rd_chk("rst_status", 8'h10, 16'h0000, 16'h0000);
      rd_chk("rst_data", 8'h11, 16'h0000, 16'h0000);

      // 1: basic read, response three cycles after REQ
      trig(16'h8005);
      chk("t1_req", 32'({req_c, req_t}), 32'b11);
      chk("t1_cnt", 32'(cnt_c), 32'd5);
      step();
      chk("t1_req_drop", 32'({req_c, req_t}), 32'd0);
      rd_chk("t1_busy", 8'h10, 16'h0001, 16'h0001);
      step();
      respond(8'hA5, 8'h00);
      rd_chk("t1_data", 8'h11, 16'h4411, 16'h4411);
      rd_chk("t1_status", 8'h10, 16'h0002, 16'h0002);
      rd_chk("t1_index", 8'h12, 16'h0005, 16'h0005);

      // 2: TCAM mask; response during REQ ignored; refresh with done set -> set wins
      trig(16'h8003);
      read_data = 8'hFF; read_mask = 8'h00; read_vld = 1'b1;
      step();
      read_vld = 1'b0;
      chk("t2_req_drop", 32'({req_c, req_t}), 32'd0);
      rd_chk("t2_busy", 8'h10, 16'h0001, 16'h0001);
      refresh = 1'b1;
      respond(8'h0F, 8'hF0);
      refresh = 1'b0;
      rd_chk("t2_data", 8'h11, 16'h0055, 16'hAA55);
      rd_chk("t2_status", 8'h10, 16'h0002, 16'h0002);
      rd_chk("t2_index", 8'h12, 16'h0003, 16'h0003);

      // 3: trigger collision during WAIT
      trig(16'h8007);
      step();
      trig(16'h8009);
      chk("t3_no_req", 32'({req_c, req_t}), 32'd0);
      respond(8'h3C, 8'h00);
      rd_chk("t3_status", 8'h10, 16'h0102, 16'h0102);
      rd_chk("t3_index", 8'h12, 16'h0007, 16'h0007);
      rd_chk("t3_data", 8'h11, 16'h0550, 16'h0550);

      // Response outside WAIT ignored
      respond(8'hFF, 8'h00);
      rd_chk("idle_vld_data", 8'h11, 16'h0550, 16'h0550);
      rd_chk("idle_vld_status", 8'h10, 16'h0102, 16'h0102);

`ifdef CAM_RD_TIMEOUT_EN
      // 4: timeout after 10 WAIT cycles
      trig(16'h8001);
      step();
      repeat (9) step();
      rd_chk("t4_still_busy", 8'h10, 16'h0101, 16'h0101);
      rd_chk("t4_timeout", 8'h10, 16'h0204, 16'h0204);
      rd_chk("t4_data_clr", 8'h11, 16'h0000, 16'h0000);
      refresh = 1'b1; step(); refresh = 1'b0;
      rd_chk("t4_refresh", 8'h10, 16'h0200, 16'h0200);
`else
      // 4: no timeout, WAIT persists until a response
      trig(16'h8001);
      repeat (20) step();
      rd_chk("t4_wait_busy", 8'h10, 16'h0101, 16'h0101);
      respond(8'h81, 8'h81);
      rd_chk("t4_status", 8'h10, 16'h0102, 16'h0102);
      rd_chk("t4_data", 8'h11, 16'h4001, 16'h8002);
`endif

      // err_cnt saturation with a held trigger
      we = 1'b1; we_addr = 8'h13; din = 16'h8001; din_v = 1'b1;
      repeat (300) step();
      we = 1'b0; din_v = 1'b0;
      respond(8'h00, 8'h00);
      repeat (15) step();
      rd_reg(8'h10);
      chk("sat_err_cam", 32'(rc[15:8]), 32'hFF);
      chk("sat_err_tcam", 32'(rt[15:8]), 32'hFF);
      chk("sat_idle", 32'({rc[0], rt[0]}), 32'd0);
      err_clr = 1'b1; refresh = 1'b1;
      step();
      err_clr = 1'b0; refresh = 1'b0;
      rd_chk("sat_clr", 8'h10, 16'h0000, 16'h0000);

      // 5: clear coinciding with collision increment; read hold; unmapped read
      trig(16'h8002);
      step();
      err_clr = 1'b1;
      trig(16'h8008);
      err_clr = 1'b0;
      rd_chk("t5_status", 8'h10, 16'h0001, 16'h0001);
      respond(8'h00, 8'h00);
      rd_chk("t5_index", 8'h12, 16'h0002, 16'h0002);
      step();
      chk("t5_hold_dout", 32'(dout_c), 32'h0002);
      chk("t5_hold_v", 32'({dv_c, dv_t}), 32'd0);
      rd_chk("t5_unmapped", 8'h05, 16'h0000, 16'h0000);

      // 6: async reset during WAIT, then a late response
      trig(16'h8004);
      rd = 1'b1; rd_addr = 8'h10;
      step();
      rd = 1'b0;
      chk("t6_pre_dout", 32'(dout_c), 32'h0001);
      rst = 1'b1;
      #1;
      chk("t6_rst_out", 32'({req_c, req_t, dv_c, dv_t}), 32'd0);
      chk("t6_rst_dout", 32'({dout_c, dout_t}), 32'd0);
      step();
      rst = 1'b0;
      respond(8'hFF, 8'h00);
      rd_chk("t6_status", 8'h10, 16'h0000, 16'h0000);
      rd_chk("t6_data", 8'h11, 16'h0000, 16'h0000);
      rd_chk("t6_index", 8'h12, 16'h0000, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
